// File: rtl/receptor_pkg.sv
// receptor_pkg: state and error encodings shared by the packet receive sequencer.
package receptor_pkg;

    // Sequencer states; the encoding is exported on db_estado.
    typedef enum logic [2:0] {
        ESPERA_CAB   = 3'b000,
        RECEBE_DADOS = 3'b001,
        RECEBE_CHECK = 3'b010,
        VALIDO       = 3'b011,
        ERRO         = 3'b100
    } estado_t;

    // Values reported on codigo_erro.
    localparam logic [2:0] ERR_NENHUM   = 3'b000;
    localparam logic [2:0] ERR_PARIDADE = 3'b001;
    localparam logic [2:0] ERR_FORMATO  = 3'b010;
    localparam logic [2:0] ERR_CHECKSUM = 3'b011;
    localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

    // Header bits [15:8] that mark the start of a packet.
    localparam logic [7:0] SYNC_PADRAO = 8'hA5;

endpackage

// File: rtl/controle_pacote_rx_contador_timeout.sv
// contador_timeout: counts idle cycles between words of a packet and flags
// expiry on the TIMEOUT_CYCLES-th clock edge after the last clear.
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_limpa,
    input  logic i_habilita,
    output logic o_expirou
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_contagem;

    // Idle-cycle counter: cleared on request, saturates once expired.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of process ordering.
        if (reset) begin
            r_contagem <= '0;
        end else if (i_limpa) begin
            r_contagem <= '0;
        end else if (i_habilita && !o_expirou) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    // Count starts at 0 in the cycle after a clear, so value T-1 is reached
    // in the cycle that ends with the T-th edge.
    assign o_expirou = i_habilita && (r_contagem == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/controle_pacote_rx.sv
// controle_pacote_rx: assembles receiver words into header/payload/checksum
// packets, writes the payload into the register bank and validates the frame.
module controle_pacote_rx
    import receptor_pkg::*;
#(
    parameter logic [7:0] SYNC           = SYNC_PADRAO,
    parameter int         MAX_WORDS      = 8,
    parameter int         TIMEOUT_CYCLES = 5_000_000,
    parameter int         AW             = $clog2(MAX_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [15:0]   rx_data,
    input  logic          rx_pronto,
    input  logic          rx_erro,
    input  logic          consumido,
    output logic          escreve,
    output logic [AW-1:0] endereco,
    output logic [15:0]   dado,
    output logic [AW:0]   tamanho,
    output logic          pacote_valido,
    output logic          erro,
    output logic [2:0]    codigo_erro,
    output logic [2:0]    db_estado
);

    estado_t       r_estado;
    estado_t       w_prox_estado;

    logic [15:0]   r_soma;
    logic [AW-1:0] r_idx;
    logic          r_escreve;
    logic [AW-1:0] r_endereco;
    logic [15:0]   r_dado;
    logic [AW:0]   r_tamanho;
    logic          r_pacote_valido;
    logic          r_erro;
    logic [2:0]    r_codigo;

    logic [15:0]   w_soma;
    logic [AW-1:0] w_idx;
    logic          w_escreve;
    logic [AW-1:0] w_endereco;
    logic [15:0]   w_dado;
    logic [AW:0]   w_tamanho;
    logic [2:0]    w_codigo;

    logic          w_bom;
    logic          w_cab_sync;
    logic          w_cab_tam_ok;
    logic          w_ultima;
    logic          w_em_recepcao;
    logic          w_expirou;

    assign w_bom         = rx_pronto && !rx_erro;
    assign w_cab_sync    = (rx_data[15:8] == SYNC);
    assign w_cab_tam_ok  = (rx_data[7:0] != 8'd0) && (rx_data[7:0] <= 8'(MAX_WORDS));
    assign w_ultima      = ({1'b0, r_idx} == (r_tamanho - 1'b1));
    assign w_em_recepcao = (r_estado == RECEBE_DADOS) || (r_estado == RECEBE_CHECK);

    // Inter-word watchdog; restarts on every word and whenever idle.
    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .i_limpa    (rx_pronto || !w_em_recepcao),
        .i_habilita (w_em_recepcao),
        .o_expirou  (w_expirou)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= ESPERA_CAB;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Next-state logic; a word arriving together with expiry takes priority.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_prox_estado = r_estado;
        unique case (r_estado)
            ESPERA_CAB: begin
                if (w_bom && w_cab_sync) begin
                    w_prox_estado = w_cab_tam_ok ? RECEBE_DADOS : ERRO;
                end
            end
            RECEBE_DADOS: begin
                if (rx_pronto) begin
                    if (rx_erro)       w_prox_estado = ERRO;
                    else if (w_ultima) w_prox_estado = RECEBE_CHECK;
                end else if (w_expirou) begin
                    w_prox_estado = ERRO;
                end
            end
            RECEBE_CHECK: begin
                if (rx_pronto) begin
                    w_prox_estado = (!rx_erro && rx_data == r_soma) ? VALIDO : ERRO;
                end else if (w_expirou) begin
                    w_prox_estado = ERRO;
                end
            end
            VALIDO: begin
                if (consumido) w_prox_estado = ESPERA_CAB;
            end
            ERRO:    w_prox_estado = ESPERA_CAB;
            default: w_prox_estado = ESPERA_CAB;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        w_escreve  = 1'b0;
        w_endereco = r_endereco;
        w_dado     = r_dado;
        w_tamanho  = r_tamanho;
        w_codigo   = r_codigo;
        w_soma     = r_soma;
        w_idx      = r_idx;
        unique case (r_estado)
            ESPERA_CAB: begin
                if (w_bom && w_cab_sync) begin
                    if (w_cab_tam_ok) begin
                        w_tamanho = rx_data[AW:0];
                        w_soma    = rx_data;
                        w_idx     = '0;
                        w_codigo  = ERR_NENHUM;
                    end else begin
                        w_codigo  = ERR_FORMATO;
                    end
                end
            end
            RECEBE_DADOS: begin
                if (rx_pronto) begin
                    if (rx_erro) begin
                        w_codigo = ERR_PARIDADE;
                    end else begin
                        w_escreve  = 1'b1;
                        w_endereco = r_idx;
                        w_dado     = rx_data;
                        w_soma     = r_soma + rx_data;
                        w_idx      = r_idx + 1'b1;
                    end
                end else if (w_expirou) begin
                    w_codigo = ERR_TIMEOUT;
                end
            end
            RECEBE_CHECK: begin
                if (rx_pronto) begin
                    if (rx_erro)                 w_codigo = ERR_PARIDADE;
                    else if (rx_data != r_soma)  w_codigo = ERR_CHECKSUM;
                end else if (w_expirou) begin
                    w_codigo = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; flags follow the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_escreve       <= 1'b0;
            r_endereco      <= '0;
            r_dado          <= '0;
            r_tamanho       <= '0;
            r_codigo        <= ERR_NENHUM;
            r_soma          <= '0;
            r_idx           <= '0;
            r_pacote_valido <= 1'b0;
            r_erro          <= 1'b0;
        end else begin
            r_escreve       <= w_escreve;
            r_endereco      <= w_endereco;
            r_dado          <= w_dado;
            r_tamanho       <= w_tamanho;
            r_codigo        <= w_codigo;
            r_soma          <= w_soma;
            r_idx           <= w_idx;
            r_pacote_valido <= (w_prox_estado == VALIDO);
            r_erro          <= (w_prox_estado == ERRO);
        end
    end

    assign escreve       = r_escreve;
    assign endereco      = r_endereco;
    assign dado          = r_dado;
    assign tamanho       = r_tamanho;
    assign pacote_valido = r_pacote_valido;
    assign erro          = r_erro;
    assign codigo_erro   = r_codigo;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_controle_pacote_rx.sv
// tb_controle_pacote_rx: directed scenarios plus randomized packets checked
// against a packet-level model of the receive sequencer.
module tb_controle_pacote_rx;

    localparam int TO = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_pronto;
    logic        rx_erro;
    logic        consumido;
    logic        escreve;
    logic [2:0]  endereco;
    logic [15:0] dado;
    logic [3:0]  tamanho;
    logic        pacote_valido;
    logic        erro;
    logic [2:0]  codigo_erro;
    logic [2:0]  db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    // Passive monitor log, written only by the monitor process.
    logic [18:0] wr_log[$];
    int          erro_cnt = 0;
    logic [2:0]  erro_cod = 3'b000;

    controle_pacote_rx #(
        .SYNC           (8'hA5),
        .MAX_WORDS      (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_pronto     (rx_pronto),
        .rx_erro       (rx_erro),
        .consumido     (consumido),
        .escreve       (escreve),
        .endereco      (endereco),
        .dado          (dado),
        .tamanho       (tamanho),
        .pacote_valido (pacote_valido),
        .erro          (erro),
        .codigo_erro   (codigo_erro),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (escreve) wr_log.push_back({endereco, dado});
        if (erro) begin
            erro_cnt = erro_cnt + 1;
            erro_cod = codigo_erro;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] w, input logic pe, input logic ack);
        rx_data   = w;
        rx_pronto = 1'b1;
        rx_erro   = pe;
        consumido = ack;
        step(1);
        rx_pronto = 1'b0;
        rx_erro   = 1'b0;
        consumido = 1'b0;
        rx_data   = 16'h0000;
    endtask

    task automatic consume();
        consumido = 1'b1;
        step(1);
        consumido = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({escreve, endereco, dado, tamanho, pacote_valido, erro, codigo_erro, db_estado} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {escreve, endereco, dado, tamanho, pacote_valido, erro, codigo_erro, db_estado});
        end
        reset = 1'b0;
        step(2);
        n_checks++;
        if (db_estado !== 3'b000 || pacote_valido !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle estado=%0d valido=%0b expected 0/0", db_estado, pacote_valido);
        end
    endtask

    task automatic test_good_packet();
        send(16'hA503, 1'b0, 1'b0);
        n_checks++;
        if (escreve !== 1'b0 || db_estado !== 3'd1) begin
            n_fail++;
            $display("FAIL good_header escreve=%0b estado=%0d expected 0/1", escreve, db_estado);
        end
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(0, 3));
            send(16'(i + 1), 1'b0, 1'b0);
            n_checks++;
            if (escreve !== 1'b1 || endereco !== 3'(i) || dado !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL good_write%0d escreve=%0b addr=%0d dado=%h expected 1/%0d/%h",
                         i, escreve, endereco, dado, i, i + 1);
            end
        end
        n_checks++;
        if (db_estado !== 3'd2) begin
            n_fail++;
            $display("FAIL good_to_check estado=%0d expected 2", db_estado);
        end
        send(16'hA509, 1'b0, 1'b0);
        n_checks++;
        if (pacote_valido !== 1'b1 || tamanho !== 4'd3 || codigo_erro !== 3'd0 || db_estado !== 3'd3) begin
            n_fail++;
            $display("FAIL good_valid valido=%0b tam=%0d cod=%0d estado=%0d expected 1/3/0/3",
                     pacote_valido, tamanho, codigo_erro, db_estado);
        end
        step(3);
        n_checks++;
        if (pacote_valido !== 1'b1) begin
            n_fail++;
            $display("FAIL good_hold valido=%0b expected 1", pacote_valido);
        end
        consume();
        n_checks++;
        if (pacote_valido !== 1'b0 || db_estado !== 3'd0) begin
            n_fail++;
            $display("FAIL good_consumed valido=%0b estado=%0d expected 0/0", pacote_valido, db_estado);
        end
    endtask

    task automatic test_checksum();
        send(16'hA501, 1'b0, 1'b0);
        send(16'h5AFF, 1'b0, 1'b0);
        send(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (pacote_valido !== 1'b1 || db_estado !== 3'd3) begin
            n_fail++;
            $display("FAIL csum_wrap valido=%0b estado=%0d expected 1/3", pacote_valido, db_estado);
        end
        consume();
        send(16'hA501, 1'b0, 1'b0);
        send(16'h5AFF, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b0);
        n_checks++;
        if (erro !== 1'b1 || codigo_erro !== 3'd3 || pacote_valido !== 1'b0 || db_estado !== 3'd4) begin
            n_fail++;
            $display("FAIL csum_bad erro=%0b cod=%0d valido=%0b estado=%0d expected 1/3/0/4",
                     erro, codigo_erro, pacote_valido, db_estado);
        end
        step(1);
        n_checks++;
        if (erro !== 1'b0 || db_estado !== 3'd0 || codigo_erro !== 3'd3) begin
            n_fail++;
            $display("FAIL csum_after erro=%0b estado=%0d cod=%0d expected 0/0/3", erro, db_estado, codigo_erro);
        end
    endtask

    task automatic test_parity();
        int base;
        base = wr_log.size();
        send(16'hA502, 1'b0, 1'b0);
        send(16'h1234, 1'b0, 1'b0);
        send(16'h5678, 1'b1, 1'b0);
        n_checks++;
        if (erro !== 1'b1 || codigo_erro !== 3'd1) begin
            n_fail++;
            $display("FAIL parity_err erro=%0b cod=%0d expected 1/1", erro, codigo_erro);
        end
        step(1);
        n_checks++;
        if (wr_log.size() - base !== 1 || wr_log[base] !== {3'd0, 16'h1234}) begin
            n_fail++;
            $display("FAIL parity_writes count=%0d expected 1 (addr0=1234)", wr_log.size() - base);
        end
        n_checks++;
        if (db_estado !== 3'd0) begin
            n_fail++;
            $display("FAIL parity_idle estado=%0d expected 0", db_estado);
        end
    endtask

    task automatic test_format();
        send(16'h1234, 1'b0, 1'b0);
        n_checks++;
        if (db_estado !== 3'd0 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL fmt_garbage estado=%0d erro=%0b expected 0/0", db_estado, erro);
        end
        send(16'hA500, 1'b0, 1'b0);
        n_checks++;
        if (erro !== 1'b1 || codigo_erro !== 3'd2) begin
            n_fail++;
            $display("FAIL fmt_len0 erro=%0b cod=%0d expected 1/2", erro, codigo_erro);
        end
        step(1);
        send(16'hA509, 1'b0, 1'b0);
        n_checks++;
        if (erro !== 1'b1 || codigo_erro !== 3'd2) begin
            n_fail++;
            $display("FAIL fmt_len9 erro=%0b cod=%0d expected 1/2", erro, codigo_erro);
        end
        step(1);
        send(16'hA503, 1'b1, 1'b0);
        step(2);
        n_checks++;
        if (db_estado !== 3'd0 || codigo_erro !== 3'd2) begin
            n_fail++;
            $display("FAIL fmt_parity_hdr estado=%0d cod=%0d expected 0/2", db_estado, codigo_erro);
        end
        send(16'hA508, 1'b0, 1'b0);
        n_checks++;
        if (db_estado !== 3'd1 || codigo_erro !== 3'd0) begin
            n_fail++;
            $display("FAIL fmt_len8 estado=%0d cod=%0d expected 1/0", db_estado, codigo_erro);
        end
        for (int i = 0; i < 8; i++) send(16'(i + 1), 1'b0, 1'b0);
        n_checks++;
        if (endereco !== 3'd7 || dado !== 16'd8 || db_estado !== 3'd2) begin
            n_fail++;
            $display("FAIL fmt_len8_last addr=%0d dado=%h estado=%0d expected 7/0008/2", endereco, dado, db_estado);
        end
        send(16'hA52C, 1'b0, 1'b0);
        n_checks++;
        if (pacote_valido !== 1'b1 || tamanho !== 4'd8) begin
            n_fail++;
            $display("FAIL fmt_len8_valid valido=%0b tam=%0d expected 1/8", pacote_valido, tamanho);
        end
        consume();
    endtask

    task automatic test_timeout();
        logic early;
        int   base;
        send(16'hA502, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b0);
        early = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (erro) early = 1'b1;
            step(1);
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early erro seen before edge %0d", TO);
        end
        n_checks++;
        if (erro !== 1'b1 || codigo_erro !== 3'd4) begin
            n_fail++;
            $display("FAIL timeout_fire erro=%0b cod=%0d expected 1/4", erro, codigo_erro);
        end
        step(1);
        base = erro_cnt;
        send(16'hA502, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b0);
        step(TO - 1);
        send(16'h0002, 1'b0, 1'b0);
        n_checks++;
        if (erro !== 1'b0 || escreve !== 1'b1 || endereco !== 3'd1 || db_estado !== 3'd2) begin
            n_fail++;
            $display("FAIL timeout_word_wins erro=%0b escreve=%0b addr=%0d estado=%0d expected 0/1/1/2",
                     erro, escreve, endereco, db_estado);
        end
        step(TO - 2);
        send(16'hA505, 1'b0, 1'b0);
        n_checks++;
        if (pacote_valido !== 1'b1 || erro_cnt !== base) begin
            n_fail++;
            $display("FAIL timeout_late_valid valido=%0b errors=%0d expected 1/0", pacote_valido, erro_cnt - base);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int base;
        send(16'hA503, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({escreve, endereco, dado, tamanho, pacote_valido, erro, codigo_erro, db_estado} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got=%h expected=0",
                     {escreve, endereco, dado, tamanho, pacote_valido, erro, codigo_erro, db_estado});
        end
        step(2);
        reset = 1'b0;
        step(1);
        base = wr_log.size();
        send(16'hA502, 1'b0, 1'b0);
        send(16'h0010, 1'b0, 1'b0);
        send(16'h0020, 1'b0, 1'b0);
        send(16'hA532, 1'b0, 1'b0);
        n_checks++;
        if (pacote_valido !== 1'b1 || tamanho !== 4'd2) begin
            n_fail++;
            $display("FAIL reset_mid_next valido=%0b tam=%0d expected 1/2", pacote_valido, tamanho);
        end
        n_checks++;
        if (wr_log.size() - base !== 2 || wr_log[base] !== {3'd0, 16'h0010} || wr_log[base + 1] !== {3'd1, 16'h0020}) begin
            n_fail++;
            $display("FAIL reset_mid_writes count=%0d expected 2", wr_log.size() - base);
        end
    endtask

    task automatic test_valido_overlap();
        int base;
        base = wr_log.size();
        send(16'hA503, 1'b0, 1'b0);
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        step(2);
        n_checks++;
        if (pacote_valido !== 1'b1 || tamanho !== 4'd2 || db_estado !== 3'd3 || wr_log.size() !== base) begin
            n_fail++;
            $display("FAIL overlap_drop valido=%0b tam=%0d estado=%0d writes=%0d expected 1/2/3/0",
                     pacote_valido, tamanho, db_estado, wr_log.size() - base);
        end
        consume();
        send(16'hA501, 1'b0, 1'b0);
        send(16'h00FF, 1'b0, 1'b0);
        send(16'hA600, 1'b0, 1'b0);
        n_checks++;
        if (pacote_valido !== 1'b1 || tamanho !== 4'd1) begin
            n_fail++;
            $display("FAIL overlap_next valido=%0b tam=%0d expected 1/1", pacote_valido, tamanho);
        end
        consume();
    endtask

    // Packet-level model: outcome follows from the kind of packet built.
    // kind 0 good, 1 bad checksum, 2 parity error, 3 bad length, 4 good after noise.
    task automatic test_random(input int n_pkts);
        int          kind, len, k, base_wr, base_err, exp_writes;
        logic        exp_valid, pe, bad_wr;
        logic [2:0]  exp_code;
        logic [15:0] hdr, sum, chk;
        logic [15:0] pay[$];
        for (int p = 0; p < n_pkts; p++) begin
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, 8);
            k    = $urandom_range(0, len);
            pay.delete();
            hdr = {8'hA5, 8'(len)};
            sum = hdr;
            for (int i = 0; i < len; i++) begin
                pay.push_back(16'($urandom));
                sum = sum + pay[i];
            end
            chk        = (kind == 1) ? sum + 16'($urandom_range(1, 65535)) : sum;
            exp_valid  = (kind == 0 || kind == 4);
            exp_writes = (kind == 3) ? 0 : (kind == 2) ? k : len;
            case (kind)
                1:       exp_code = 3'd3;
                2:       exp_code = 3'd1;
                3:       exp_code = 3'd2;
                default: exp_code = 3'd0;
            endcase
            base_wr  = wr_log.size();
            base_err = erro_cnt;

            if (kind == 4) begin
                send({8'($urandom_range(0, 8'hA4)), 8'($urandom)}, 1'b0, 1'($urandom_range(0, 1)));
                step($urandom_range(0, 3));
                send({8'hA5, 8'($urandom_range(1, 8))}, 1'b1, 1'b0);
            end
            step($urandom_range(0, 3));
            if (kind == 3) begin
                send({8'hA5, ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255))}, 1'b0, 1'b0);
            end else begin
                send(hdr, 1'b0, 1'($urandom_range(0, 1)));
                pe = 1'b0;
                for (int i = 0; i < len && !pe; i++) begin
                    step($urandom_range(0, 3));
                    pe = (kind == 2 && i == k);
                    send(pay[i], pe, 1'($urandom_range(0, 1)));
                end
                if (!pe) begin
                    step($urandom_range(0, 3));
                    send(chk, (kind == 2 && k == len), 1'b0);
                end
            end
            step(1);

            bad_wr = (wr_log.size() - base_wr != exp_writes);
            if (!bad_wr) begin
                for (int i = 0; i < exp_writes; i++)
                    if (wr_log[base_wr + i] !== {3'(i), pay[i]}) bad_wr = 1'b1;
            end
            n_checks++;
            if (bad_wr) begin
                n_fail++;
                $display("FAIL rand%0d_writes kind=%0d count=%0d expected %0d", p, kind,
                         wr_log.size() - base_wr, exp_writes);
            end
            n_checks++;
            if (erro_cnt - base_err !== (exp_valid ? 0 : 1) || codigo_erro !== exp_code) begin
                n_fail++;
                $display("FAIL rand%0d_error kind=%0d pulses=%0d cod=%0d expected %0d/%0d", p, kind,
                         erro_cnt - base_err, codigo_erro, exp_valid ? 0 : 1, exp_code);
            end
            n_checks++;
            if (pacote_valido !== exp_valid || (exp_valid && tamanho !== 4'(len))) begin
                n_fail++;
                $display("FAIL rand%0d_valid kind=%0d valido=%0b tam=%0d expected %0b/%0d", p, kind,
                         pacote_valido, tamanho, exp_valid, len);
            end
            if (exp_valid) consume();
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = 16'h0000;
        rx_pronto = 1'b0;
        rx_erro   = 1'b0;
        consumido = 1'b0;
        step(2);
        test_reset();
        test_good_packet();
        test_checksum();
        test_parity();
        test_format();
        test_timeout();
        test_reset_mid();
        test_valido_overlap();
        test_random(40);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
